// File: rtl/dmem_responder.sv
// Word-organised data RAM behind the memory stage: masked byte writes, reads after READ_LATENCY cycles.
// Define DMEM_BOUNDS_CHECK_EN to suppress out-of-range accesses and report them on o_dmem_err.
module dmem_responder #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_rvalid,
    output logic        o_dmem_busy,
    output logic        o_dmem_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] idx_q;
    logic          rd_oob_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] widx;
    logic          accept, oob, we, rd_acc;
    logic [31:0]   rd_word;
    logic          unused_addr;

    assign widx        = i_dmem_addr[AW+1:2];
    assign unused_addr = ^i_dmem_addr;
    assign accept      = (state != READ_WAIT);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |(i_dmem_addr[31:2] >> AW);
`else
    assign oob = 1'b0;
`endif

    assign we     = accept & i_dmem_wen & ~oob;
    assign rd_acc = accept & i_dmem_ren;

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_dmem_mask[b]) mem[widx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (rd_acc) begin
                    cnt_nxt   = 4'(READ_LATENCY - 1);
                    state_nxt = (READ_LATENCY == 1) ? RESP : READ_WAIT;
                end
            end
            READ_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            rd_oob_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_acc) begin
                idx_q    <= widx;
                rd_oob_q <= oob;
            end
            if (state == RESP) rdata_q <= rd_word;
        end
    end

    // The write of a combined ren+wen lands at acceptance, so reading in RESP is write-first.
    assign rd_word       = rd_oob_q ? 32'd0 : mem[idx_q];
    assign o_dmem_rdata  = (state == RESP) ? rd_word : rdata_q;
    assign o_dmem_rvalid = (state == RESP);
    assign o_dmem_busy   = (state == READ_WAIT);

`ifdef DMEM_BOUNDS_CHECK_EN
    // Write-only OOB flags on the next cycle; OOB reads flag alongside rvalid.
    logic wr_err_q;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) wr_err_q <= 1'b0;
        else        wr_err_q <= accept & i_dmem_wen & ~i_dmem_ren & oob;
    end
    assign o_dmem_err = wr_err_q | ((state == RESP) & rd_oob_q);
`else
    assign o_dmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder; two instances (latency 1 and 4) share one stimulus
// stream and are checked every cycle against a queue-free countdown model of the memory.
module tb_dmem_responder;
    localparam int DEPTH = 16;
    localparam int NI    = 2;
    localparam int LAT0  = 1;
    localparam int LAT1  = 4;

    bit          clk = 0;
    logic        rst_n;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    logic [31:0] rdata  [NI];
    logic        rvalid [NI];
    logic        busy   [NI];
    logic        err    [NI];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .READ_LATENCY(LAT0)) u_dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_dmem_ren(ren), .i_dmem_wen(wen),
        .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_mask(mask),
        .o_dmem_rdata(rdata[0]), .o_dmem_rvalid(rvalid[0]),
        .o_dmem_busy(busy[0]), .o_dmem_err(err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .READ_LATENCY(LAT1)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_dmem_ren(ren), .i_dmem_wen(wen),
        .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_mask(mask),
        .o_dmem_rdata(rdata[1]), .o_dmem_rvalid(rvalid[1]),
        .o_dmem_busy(busy[1]), .o_dmem_err(err[1])
    );

    // ---------------- behavioural model ----------------
    // left[k]: cycles until rvalid counting the current cycle as 1; 0 means nothing outstanding.
    bit [31:0] mmem      [NI][DEPTH];
    int        left      [NI];
    bit [31:0] pend_data [NI];
    bit        pend_oob  [NI];
    bit [31:0] exp_rdata [NI];
    bit        wr_err    [NI];

    function automatic int lat(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_step(input int k);
        bit        acc, oob;
        int        widx;
        bit [31:0] wa;
        acc       = (left[k] < 2);
        wr_err[k] = 0;
        if (left[k] > 0) left[k]--;
        wa   = {2'b00, addr[31:2]};
        oob  = 0;
`ifdef DMEM_BOUNDS_CHECK_EN
        oob  = (wa >= 32'(DEPTH));
`endif
        widx = int'(wa % 32'(DEPTH));
        if (acc && wen && !oob)
            for (int b = 0; b < 4; b++)
                if (mask[b]) mmem[k][widx][8*b +: 8] = wdata[8*b +: 8];
        if (acc && ren) begin
            left[k]      = lat(k);
            pend_oob[k]  = oob;
            pend_data[k] = oob ? 32'd0 : mmem[k][widx];
        end else if (acc && wen && oob) begin
            wr_err[k] = 1;
        end
        if (left[k] == 1) exp_rdata[k] = pend_data[k];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                left[k] = 0; exp_rdata[k] = 0; wr_err[k] = 0; pend_oob[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) model_step(k);
        end
    end

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Every-cycle compare; outputs depend only on registered state, so negedge is stable.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            check("busy",   k, 32'(busy[k]),   32'(left[k] >= 2));
            check("rvalid", k, 32'(rvalid[k]), 32'(left[k] == 1));
            check("err",    k, 32'(err[k]),    32'(wr_err[k] || (left[k] == 1 && pend_oob[k])));
            check("rdata",  k, rdata[k],       exp_rdata[k]);
        end
    end

    // ---------------- stimulus helpers (always entered at negedge+1) ----------------
    task automatic idle(input int n);
        ren = 0; wen = 0;
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        ren = r; wen = w; addr = a; wdata = d; mask = m;
        @(negedge clk); #1;
        ren = 0; wen = 0;
    endtask

    task automatic wait_rv(input int k, output logic [31:0] d, output logic e);
        int n;
        n = 0; d = '0; e = 0;
        while (!rvalid[k] && n < 12) begin @(negedge clk); #1; n++; end
        if (!rvalid[k]) begin
            n_checks++; n_err++;
            $display("FAIL rvalid_timeout[%0d]: no rvalid within 12 cycles", k);
        end else begin
            d = rdata[k]; e = err[k];
        end
    endtask

    logic [31:0] d;
    logic        e;

    initial begin
        rst_n = 0; ren = 0; wen = 0; addr = 0; wdata = 0; mask = 0;
        @(negedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_rdata",  k, rdata[k], 32'd0);
            check("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
            check("rst_busy",   k, 32'(busy[k]), 32'd0);
            check("rst_err",    k, 32'(err[k]), 32'd0);
        end
        rst_n = 1;
        @(negedge clk); #1;

        // Fill every word so RAM contents are known to the model.
        for (int i = 0; i < DEPTH; i++) req(0, 1, 32'(i * 4), $urandom, 4'hF);
        idle(2);

        // Masked byte writes.
        req(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111);
        req(0, 1, 32'h10, 32'h000000AA, 4'b0001);
        req(0, 1, 32'h10, 32'h55000000, 4'b1000);
        req(1, 0, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < NI; k++) begin
            wait_rv(k, d, e);
            check("masked_rd", k, d, 32'h55ADBEAA);
        end
        idle(6);

        // Latency/busy profile on the latency-4 instance.
        req(0, 1, 32'h20, 32'h11223344, 4'hF);
        idle(1);
        req(1, 0, 32'h20, 32'h0, 4'h0);
        for (int i = 1; i <= LAT1; i++) begin
            check("lat_busy",   1, 32'(busy[1]),   32'(i < LAT1));
            check("lat_rvalid", 1, 32'(rvalid[1]), 32'(i == LAT1));
            if (i < LAT1) begin @(negedge clk); #1; end
        end
        check("lat_rdata", 1, rdata[1], 32'h11223344);
        idle(6);

        // Simultaneous ren+wen returns the post-write word.
        req(1, 1, 32'h20, 32'hFFFFFFFF, 4'b0110);
        for (int k = 0; k < NI; k++) begin
            wait_rv(k, d, e);
            check("rw_first", k, d, 32'h11FFFF44);
        end
        idle(6);

        // Write during busy is dropped (instance 1), accepted in RESP (instance 0).
        req(0, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        req(1, 0, 32'h30, 32'h0, 4'h0);
        req(0, 1, 32'h30, 32'h12345678, 4'hF);
        idle(6);
        req(1, 0, 32'h30, 32'h0, 4'h0);
        wait_rv(0, d, e); check("wr_in_resp", 0, d, 32'h12345678);
        wait_rv(1, d, e); check("wr_in_busy", 1, d, 32'hCAFEF00D);
        idle(6);

        // Back-to-back reads on the latency-1 instance.
        req(1, 0, 32'h30, 32'h0, 4'h0);
        check("b2b_first", 0, rdata[0], 32'h12345678);
        req(1, 0, 32'h20, 32'h0, 4'h0);
        check("b2b_rvalid", 0, 32'(rvalid[0]), 32'd1);
        check("b2b_second", 0, rdata[0], 32'h11FFFF44);
        idle(6);

        // Bounds: byte address 0x40 is word 16 of a 16-word RAM.
        req(0, 1, 32'h0, 32'h0BADF00D, 4'hF);
        req(0, 1, 32'h40, 32'hA5A5A5A5, 4'hF);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("oob_wr_err", 0, 32'(err[0]), 32'd1);
`else
        check("oob_wr_err", 0, 32'(err[0]), 32'd0);
`endif
        idle(6);
        req(1, 0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < NI; k++) begin
            wait_rv(k, d, e);
`ifdef DMEM_BOUNDS_CHECK_EN
            check("word0_after_oob", k, d, 32'h0BADF00D);
`else
            check("word0_after_wrap", k, d, 32'hA5A5A5A5);
`endif
        end
        idle(6);
        req(1, 0, 32'h40, 32'h0, 4'h0);
        for (int k = 0; k < NI; k++) begin
            wait_rv(k, d, e);
`ifdef DMEM_BOUNDS_CHECK_EN
            check("oob_rd_data", k, d, 32'h0);
            check("oob_rd_err",  k, 32'(e), 32'd1);
`else
            check("wrap_rd_data", k, d, 32'hA5A5A5A5);
            check("wrap_rd_err",  k, 32'(e), 32'd0);
`endif
        end
        idle(6);

        // Random traffic, mostly in range, sometimes wrapping / out of bounds.
        for (int i = 0; i < 800; i++) begin
            ren   = ($urandom_range(0, 2) == 0);
            wen   = ($urandom_range(0, 1) == 0);
            addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
            wdata = $urandom;
            mask  = 4'($urandom_range(0, 15));
            @(negedge clk); #1;
        end
        idle(6);

        // Reset in the middle of a latency-4 read aborts it.
        req(1, 0, 32'h8, 32'h0, 4'h0);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("midrst_rdata",  k, rdata[k], 32'd0);
            check("midrst_rvalid", k, 32'(rvalid[k]), 32'd0);
            check("midrst_busy",   k, 32'(busy[k]), 32'd0);
        end
        @(negedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            check("no_rvalid_after_rst", 1, 32'(rvalid[1]), 32'd0);
            @(negedge clk); #1;
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's memory-stage interface.
- Accepts the core's word address, write data and byte mask, and performs masked byte writes into a word-organised RAM.
- Returns read data after a programmable latency, with a busy/valid handshake.
- Serves as the dmem model for integration and as the synthesizable scratchpad behind the memory stage.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, >= 2.
- READ_LATENCY, 1, cycles from accepted read to o_dmem_rvalid; legal range 1..15.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous assert, active-low.
- i_dmem_ren  input  1  read request.
- i_dmem_wen  input  1  write request.
- i_dmem_addr  input  32  byte address; bits [1:0] ignored; word index = addr[31:2].
- i_dmem_wdata  input  32  write data, already lane-aligned by the memory stage.
- i_dmem_mask  input  4  byte-lane write enables; bit n enables wdata[8n+7:8n].
- o_dmem_rdata  output  32  full read word; the memory stage performs lane extraction.
- o_dmem_rvalid  output  1  one-cycle pulse, rdata valid.
- o_dmem_busy  output  1  high while a read is outstanding; requests are ignored while high.
- o_dmem_err  output  1  one-cycle error pulse; only driven when the optional feature is compiled in.

Behaviour:
- Reset (i_rst low, async):
  - Outputs cleared: rdata=0, rvalid=0, busy=0, err=0.
  - FSM goes to IDLE and the latency counter goes to 0.
  - RAM contents are not reset.
  - Reset during READ_WAIT aborts the read; no rvalid is produced afterwards.
- FSM states: IDLE, READ_WAIT, RESP.
- IDLE, request accepted when busy=0:
  - wen=1: at that edge, each RAM byte with mask[n]=1 takes wdata[8n+7:8n]. Other bytes are unchanged. mask=0 is a legal no-op write. No response is produced; the FSM stays in IDLE.
  - ren=1: the word index is latched and the counter is loaded with READ_LATENCY-1.
    - READ_LATENCY=1: go to RESP.
    - Otherwise: go to READ_WAIT with busy=1 from the next cycle.
  - ren=1 and wen=1 together: the masked write is applied first. The read returns the post-write word (write-first).
- READ_WAIT:
  - The counter decrements each cycle; go to RESP when it reaches 0.
  - i_dmem_* inputs are ignored; no RAM write may occur.
  - busy=1.
- RESP:
  - rdata = RAM[latched index] and rvalid=1 for exactly one cycle.
  - Return to IDLE; busy=0 in this cycle.
  - A new request presented in the RESP cycle is accepted (back-to-back reads).
- Accepted-read to rvalid spacing is exactly READ_LATENCY cycles.
- o_dmem_rdata holds its last value until the next RESP.
- Word index width is log2(DEPTH). Address bits above that are discarded, so addresses wrap modulo DEPTH*4 bytes.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - addr[31:2] >= DEPTH makes the request out of bounds.
  - OOB write: suppressed, and err pulses 1 cycle after acceptance.
  - OOB read: completes with normal latency, rdata=0, and err pulses in the same cycle as rvalid.
  - ren+wen together OOB: a single err pulse, coincident with rvalid.
- Undefined: no bounds check, addresses wrap modulo DEPTH, and o_dmem_err is tied 0.

Test Plan:
- Reset mid-read (READ_LATENCY=4): accept a read, drop i_rst after 2 cycles -> all outputs 0 immediately; no rvalid within the next 8 cycles.
- Masked writes: write 0xDEADBEEF mask 1111 to addr 0x10, then 0x000000AA mask 0001, then 0x55000000 mask 1000, then read -> rdata=0x55ADBEAA.
- Latency and busy (READ_LATENCY=3): read accepted at cycle t -> busy=1 at t+1..t+2, rvalid=1 only at t+3, busy=0 at t+3.
- Back-to-back reads plus write-during-busy (READ_LATENCY=2): write attempted while busy is dropped; read issued in the RESP cycle is accepted and returns 2 cycles later.
- Simultaneous ren+wen: addr 0x20 holds 0x11223344; wdata 0xFFFFFFFF, mask 0110 -> rdata=0x11FFFF44.
- Bounds (DEPTH=16):
  - With DMEM_BOUNDS_CHECK_EN, write to 0x40 -> err pulse, word 0 unchanged; read 0x40 -> rdata=0, err with rvalid.
  - Without it, a write to 0x40 lands in word 0, err stays 0.
